// File: rtl/bldc_multiphase.sv
// Multi-phase BLDC/PMSM commutation generator: a velocity-integrated electrical angle
// drives per-phase triangle/block duties, PWM carriers and dead-time gate FSMs.

module bldc_phase #(
  parameter int PWM_BITS = 8,
  parameter int DEADTIME = 4,
  parameter int PH_OFS   = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          base_i,
  input  logic                tri_i,
  input  logic                blk_i,
  input  logic                latch_i,
  input  logic [PWM_BITS-1:0] cnt_i,
  input  logic                drive_i,
  output logic [PWM_BITS-1:0] duty_o,
  output logic                hi_o,
  output logic                lo_o
);
  localparam int DW = $clog2(DEADTIME + 1);
  localparam logic [7:0] OFS = 8'(PH_OFS);

  typedef enum logic [1:0] {S_OFF, S_DEAD, S_HIGH, S_LOW} st_t;

  st_t                 st_q, st_d;
  logic [DW-1:0]       dc_q, dc_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [7:0]          a, tri_w;
  logic                target;

  assign a = base_i + OFS;
  // 2a below 128, 2(255-a) above; 255-a is just ~a when a[7] is set
  assign tri_w = a[7] ? {~a[6:0], 1'b0} : {a[6:0], 1'b0};

  always_comb begin
    duty_d = duty_q;
    if (latch_i) begin
      if (tri_i)      duty_d = tri_w[7 -: PWM_BITS];
      else if (blk_i) duty_d = a[7] ? '0 : '1;
      else            duty_d = '0;
    end
  end

  assign target = (cnt_i < duty_q);

  always_comb begin
    st_d = st_q;
    dc_d = dc_q;
    if (!drive_i) begin
      st_d = S_OFF;
      dc_d = '0;
    end else begin
      case (st_q)
        S_OFF: begin
          st_d = S_DEAD;
          dc_d = DW'(DEADTIME - 1);
        end
        S_DEAD: begin
          // target is only sampled at expiry; edges during the gap don't restart it
          if (dc_q == '0) st_d = target ? S_HIGH : S_LOW;
          else            dc_d = dc_q - DW'(1);
        end
        S_HIGH: if (!target) begin
          st_d = S_DEAD;
          dc_d = DW'(DEADTIME - 1);
        end
        S_LOW: if (target) begin
          st_d = S_DEAD;
          dc_d = DW'(DEADTIME - 1);
        end
        default: st_d = S_OFF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= S_OFF;
      dc_q   <= '0;
      duty_q <= '0;
    end else begin
      st_q   <= st_d;
      dc_q   <= dc_d;
      duty_q <= duty_d;
    end
  end

  assign duty_o = duty_q;
  assign hi_o   = (st_q == S_HIGH);
  assign lo_o   = (st_q == S_LOW);
endmodule

module bldc_multiphase #(
  parameter int PHASES         = 3,
  parameter int PWM_BITS       = 8,
  parameter int DEADTIME       = 4,
  parameter int DIVIDER        = 1,
  parameter int ACC_BITS       = 24,
  parameter int FEEDBACK_SHIFT = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [15:0]                  velocity,
  input  logic [7:0]                   offset,
  input  logic                         enable,
  input  logic [7:0]                   mode,
  output logic [31:0]                  feedback,
  output logic [PHASES*PWM_BITS-1:0]   pwm,
  output logic [PHASES-1:0]            hi,
  output logic [PHASES-1:0]            lo,
  output logic                         en
);
  localparam int PSW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;

  logic [PSW-1:0]      presc_q, presc_d;
  logic [ACC_BITS-1:0] acc_q, acc_d;
  logic [31:0]         pos_q, pos_d, fb_q;
  logic [PWM_BITS-1:0] cnt_q;
  logic                en_q;
  logic                tick, run, drive, latch;
  logic                tri_sel, blk_sel;
  logic [7:0]          base;
  logic [PHASES-1:0][PWM_BITS-1:0] duty;

  assign tick    = (presc_q == PSW'(DIVIDER - 1));
  assign tri_sel = enable && (mode == 8'd2);
  assign blk_sel = enable && (mode == 8'd3);
  assign run     = tri_sel || blk_sel;
  assign drive   = enable && (mode == 8'd1 || mode == 8'd2 || mode == 8'd3);
  assign latch   = &cnt_q;
  assign base    = acc_q[ACC_BITS-1 -: 8] + offset;

  always_comb begin
    presc_d = tick ? '0 : presc_q + PSW'(1);
    acc_d   = acc_q;
    pos_d   = pos_q;
    if (tick && run) begin
      acc_d = acc_q + {{(ACC_BITS-16){velocity[15]}}, velocity};
      pos_d = pos_q + {{16{velocity[15]}}, velocity};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      acc_q   <= '0;
      pos_q   <= '0;
      fb_q    <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      acc_q   <= acc_d;
      pos_q   <= pos_d;
      fb_q    <= $signed(pos_q) >>> FEEDBACK_SHIFT;
      cnt_q   <= cnt_q + PWM_BITS'(1);
      en_q    <= drive;
    end
  end

  for (genvar g = 0; g < PHASES; g++) begin : g_ph
    bldc_phase #(
      .PWM_BITS (PWM_BITS),
      .DEADTIME (DEADTIME),
      .PH_OFS   ((g * (256 / PHASES)) % 256)
    ) u_ph (
      .clk     (clk),
      .rst     (rst),
      .base_i  (base),
      .tri_i   (tri_sel),
      .blk_i   (blk_sel),
      .latch_i (latch),
      .cnt_i   (cnt_q),
      .drive_i (drive),
      .duty_o  (duty[g]),
      .hi_o    (hi[g]),
      .lo_o    (lo[g])
    );
  end

  assign pwm      = duty;
  assign feedback = fb_q;
  assign en       = en_q;
endmodule
